// File: rtl/popcount23_neuron_acc.sv
// popcount23_neuron_acc: accumulates pc_pos-pc_neg over CHUNKS beats and thresholds the sum (optional NEURON_SAT_EN saturates each addition)
module popcount23_neuron_acc #(
    parameter int                      CHUNKS = 4,
    parameter int                      ACC_W  = 8,
    parameter logic signed [ACC_W-1:0] THRESH = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [4:0]              pc_pos_i,
    input  logic [4:0]              pc_neg_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    out_act_o,
    output logic signed [ACC_W-1:0] out_sum_o
);
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    typedef enum logic {ACC, HOLD} state_t;
    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q, sum_d, out_sum_q;
    logic [CW-1:0]           cnt_q;
    logic                    out_act_q;
    logic signed [5:0]       diff;
`ifdef NEURON_SAT_EN
    logic signed [ACC_W:0]   wide;
`endif
    // Signed per-beat difference and the next running sum (wrapping or saturating)
    always_comb begin
        diff = $signed({1'b0, pc_pos_i}) - $signed({1'b0, pc_neg_i});
`ifdef NEURON_SAT_EN
        wide  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(diff);
        sum_d = (wide[ACC_W] != wide[ACC_W-1]) ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
`else
        sum_d = acc_q + ACC_W'(diff);
`endif
    end
    // Beat accumulation in ACC, result capture on the last beat, release from HOLD on out_ready
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sum_q <= '0;
            out_act_q <= 1'b0;
        end else if (state_q == HOLD) begin
            if (out_ready_i) state_q <= ACC;
        end else if (in_valid_i) begin
            if (cnt_q == CW'(CHUNKS - 1)) begin
                out_sum_q <= sum_d;
                out_act_q <= (sum_d >= THRESH);
                acc_q     <= '0;
                cnt_q     <= '0;
                state_q   <= HOLD;
            end else begin
                acc_q <= sum_d;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end
    assign in_ready_o  = (state_q == ACC);
    assign out_valid_o = (state_q == HOLD);
    assign out_sum_o   = out_sum_q;
    assign out_act_o   = out_act_q;
endmodule
